// File: rtl/control_adc_b_pkg.sv
// Shared types and constants for the ADC0808/0809 sequencer.
package adc_ctrl_pkg;

  localparam int ADC_DW = 8;
  localparam int ADC_AW = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ALE      = 3'd1,
    S_START    = 3'd2,
    S_WAIT_EOC = 3'd3,
    S_READ     = 3'd4,
    S_WAIT_LOW = 3'd5
  } adc_state_e;

  // Round-robin channel step: wraps from num_ch-1 back to 0.
  function automatic logic [ADC_AW-1:0] next_ch(input logic [ADC_AW-1:0] ch,
                                                input int               num_ch);
    return (ch == ADC_AW'(num_ch - 1)) ? '0 : ch + ADC_AW'(1);
  endfunction

endpackage

// File: rtl/control_adc_b_if.sv
// Pin bundle between the sequencer (master) and the ADC / downstream side (slave).
interface control_adc_b_if;
  import adc_ctrl_pkg::*;

  logic              init;
  logic              OE_R;
  logic [ADC_DW-1:0] datain;
  logic              CLK1;
  logic              ALE;
  logic              START;
  logic [ADC_AW-1:0] add;
  logic [ADC_DW-1:0] dataout;

  modport master (
    input  init, OE_R, datain,
    output CLK1, ALE, START, add, dataout
  );

  modport slave (
    output init, OE_R, datain,
    input  CLK1, ALE, START, add, dataout
  );

endinterface

// File: rtl/control_adc_b_clk_div.sv
// Converter clock divider: CLK1 toggles every CLK_DIV cycles, tick marks each rising toggle.
module clk_div_tick #(
  parameter int CLK_DIV = 50
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic clk1_o,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk1_q, clk1_d;
  logic          term;

  assign term = (cnt_q == CW'(CLK_DIV - 1));

  // Next-state: wrap the counter and flip CLK1 at terminal count.
  always_comb begin
    cnt_d  = term ? '0 : cnt_q + CW'(1);
    clk1_d = term ? ~clk1_q : clk1_q;
  end

  // Divider registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      clk1_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk1_q <= clk1_d;
    end
  end

  // tick is true in the cycle whose closing edge raises CLK1, so the FSM
  // updates on the same CLK edge that CLK1 rises.
  assign tick_o = term & ~clk1_q;
  assign clk1_o = clk1_q;

endmodule

// File: rtl/control_adc_b.sv
// Round-robin ALE/START sequencer for an ADC0808/0809-class converter.
module control_adc_b
  import adc_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter int NUM_CH  = 4
) (
  input  logic            CLK,
  input  logic            rst_n,
  control_adc_b_if.master bus
);

  adc_state_e        state_q;
  logic              ale_q;
  logic              start_q;
  logic [ADC_AW-1:0] add_q;
  logic [ADC_DW-1:0] dataout_q;
  logic              clk1;
  logic              tick;

  clk_div_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk_i   (CLK),
    .rst_n_i (rst_n),
    .clk1_o  (clk1),
    .tick_o  (tick)
  );

  // Conversion FSM: advances only on tick; every output is a register set on entry to its state.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ale_q     <= 1'b0;
      start_q   <= 1'b0;
      add_q     <= '0;
      dataout_q <= '0;
    end else if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (bus.init) begin
            state_q <= S_ALE;
            ale_q   <= 1'b1;
          end
        end
        S_ALE: begin
          state_q <= S_START;
          ale_q   <= 1'b0;
          start_q <= 1'b1;
        end
        S_START: begin
          state_q <= S_WAIT_EOC;
          start_q <= 1'b0;
        end
        S_WAIT_EOC: begin
          if (bus.OE_R) state_q <= S_READ;
        end
        S_READ: begin
          dataout_q <= bus.datain;
          state_q   <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          // add only moves once OE_R has dropped, keeping it paired with the
          // result for the whole OE_R-high window.
          if (!bus.OE_R) begin
            add_q <= next_ch(add_q, NUM_CH);
            if (bus.init) begin
              state_q <= S_ALE;
              ale_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          ale_q   <= 1'b0;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CLK1    = clk1;
  assign bus.ALE     = ale_q;
  assign bus.START   = start_q;
  assign bus.add     = add_q;
  assign bus.dataout = dataout_q;

endmodule

// File: tb/tb_control_adc_b.sv
// Scoreboard bench for control_adc_b: ADC stimulus pushes expected results, a monitor checks them.
module tb_control_adc_b;

  localparam int CLK_DIV = 2;
  localparam int NUM_CH  = 4;
  localparam int P       = 2 * CLK_DIV;  // CLK cycles per CLK1 period

  typedef struct {
    logic [2:0] ch;
    logic [7:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;

  control_adc_b_if bus();

  control_adc_b #(
    .CLK_DIV (CLK_DIV),
    .NUM_CH  (NUM_CH)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   model_ch = 0;
  bit   mon_en = 1'b0;
  bit   ale_seen = 1'b0;
  logic [2:0] prev_add = 3'd0;
  logic [7:0] last_data = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every advance of add retires one conversion from the scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en && bus.add !== prev_add) begin
        if (exp_q.size() == 0) begin
          check("unexpected_add_advance", {29'd0, bus.add}, {29'd0, prev_add});
        end else begin
          exp_t it;
          it = exp_q.pop_front();
          check("dataout", {24'd0, bus.dataout}, {24'd0, it.data});
          check("add_before", {29'd0, prev_add}, {29'd0, it.ch});
          check("add_after", {29'd0, bus.add}, (32'(it.ch) + 1) % NUM_CH);
        end
      end
      prev_add = bus.add;
    end
  end

  // Tracks whether ALE was seen high since last cleared.
  initial begin
    forever begin
      @(negedge CLK);
      if (bus.ALE === 1'b1) ale_seen = 1'b1;
    end
  end

  // Protocol: ALE high for one CLK1 period, then START for one period, never overlapping.
  initial begin
    forever begin
      @(negedge CLK);
      if (rst_n && bus.ALE === 1'b1) begin
        int cnt;
        cnt = 0;
        while (bus.ALE === 1'b1 && cnt < 50) begin
          check("ale_start_overlap", {31'd0, bus.START}, 32'd0);
          cnt++;
          @(negedge CLK);
        end
        check("ale_width", cnt, P);
        check("start_after_ale", {31'd0, bus.START}, 32'd1);
        cnt = 0;
        while (bus.START === 1'b1 && cnt < 50) begin
          cnt++;
          @(negedge CLK);
        end
        check("start_width", cnt, P);
      end
    end
  end

  task automatic wait_start(input logic lvl, input string name);
    int n;
    n = 0;
    while (bus.START !== lvl && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 400) check(name, {31'd0, bus.START}, {31'd0, lvl});
  endtask

  // One ADC conversion: answer the START with data d after dly CLK1 periods, hold OE_R hold periods.
  task automatic convert(input logic [7:0] d, input int dly, input int hold, input bit drop_init);
    exp_t e;
    wait_start(1'b1, "start_rise_timeout");
    check("start_add", {29'd0, bus.add}, model_ch);
    wait_start(1'b0, "start_fall_timeout");
    if (drop_init) bus.init = 1'b0;
    repeat (dly * P) @(negedge CLK);
    bus.datain = d;
    bus.OE_R   = 1'b1;
    e.ch   = 3'(model_ch);
    e.data = d;
    exp_q.push_back(e);
    last_data = d;
    model_ch = (model_ch + 1) % NUM_CH;
    repeat (hold * P) @(negedge CLK);
    bus.OE_R = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.init   = 1'b1;
    bus.OE_R   = 1'b0;
    bus.datain = 8'h00;

    // Reset held 3 CLK with init high
    repeat (3) @(negedge CLK);
    check("rst_clk1", {31'd0, bus.CLK1}, 32'd0);
    check("rst_ale", {31'd0, bus.ALE}, 32'd0);
    check("rst_start", {31'd0, bus.START}, 32'd0);
    check("rst_add", {29'd0, bus.add}, 32'd0);
    check("rst_dataout", {24'd0, bus.dataout}, 32'd0);

    // Divider timing from reset release, FSM idle with init low
    bus.init = 1'b0;
    rst_n    = 1'b1;
    prev_add = bus.add;
    mon_en   = 1'b1;
    cyc = 0;
    do begin @(posedge CLK); #1; cyc++; end while (bus.CLK1 !== 1'b1 && cyc < 20);
    check("clk1_first_rise", cyc, CLK_DIV);
    cyc = 0;
    do begin @(posedge CLK); #1; cyc++; end while (bus.CLK1 !== 1'b0 && cyc < 20);
    check("clk1_high", cyc, CLK_DIV);
    cyc = 0;
    do begin @(posedge CLK); #1; cyc++; end while (bus.CLK1 !== 1'b1 && cyc < 20);
    check("clk1_low", cyc, CLK_DIV);
    @(negedge CLK);
    check("idle_no_ale", {31'd0, ale_seen}, 32'd0);

    // Round-robin with 8'h10+channel, including the 3->0 wrap
    bus.init = 1'b1;
    convert(8'hA5, 3, 2, 1'b0);
    for (int i = 0; i < 5; i++)
      convert(8'h10 + 8'(model_ch), $urandom_range(0, 2), $urandom_range(2, 3), 1'b0);

    // Stop: drop init during WAIT_EOC on channel 2
    convert(8'($urandom_range(1, 255)), 2, 2, 1'b1);
    repeat (3 * P) @(negedge CLK);
    ale_seen = 1'b0;
    repeat (8 * P) @(negedge CLK);
    check("stop_no_ale", {31'd0, ale_seen}, 32'd0);
    check("stop_add", {29'd0, bus.add}, 32'd3);
    check("stop_dataout", {24'd0, bus.dataout}, {24'd0, last_data});

    // Resume from channel 3, randomized ADC timing and data
    bus.init = 1'b1;
    for (int i = 0; i < 4; i++)
      convert(8'($urandom_range(1, 255)), $urandom_range(0, 3), $urandom_range(2, 4), 1'b0);

    // Reset in WAIT_EOC on channel 3, then a stray OE_R pulse
    wait_start(1'b1, "rst_start_rise_timeout");
    check("pre_rst_add", {29'd0, bus.add}, model_ch);
    wait_start(1'b0, "rst_start_fall_timeout");
    @(negedge CLK);
    mon_en   = 1'b0;
    bus.init = 1'b0;
    rst_n    = 1'b0;
    @(negedge CLK);
    check("midrst_add", {29'd0, bus.add}, 32'd0);
    check("midrst_dataout", {24'd0, bus.dataout}, 32'd0);
    check("midrst_ale", {31'd0, bus.ALE}, 32'd0);
    check("midrst_start", {31'd0, bus.START}, 32'd0);
    rst_n    = 1'b1;
    model_ch = 0;
    ale_seen = 1'b0;
    prev_add = bus.add;
    mon_en   = 1'b1;
    bus.datain = 8'hEE;
    bus.OE_R   = 1'b1;
    repeat (3 * P) @(negedge CLK);
    bus.OE_R = 1'b0;
    repeat (3 * P) @(negedge CLK);
    check("stray_oe_dataout", {24'd0, bus.dataout}, 32'd0);
    check("stray_oe_add", {29'd0, bus.add}, 32'd0);
    check("stray_oe_no_ale", {31'd0, ale_seen}, 32'd0);

    // Recovery conversion on channel 0
    bus.init = 1'b1;
    convert(8'h5A, 1, 2, 1'b1);
    repeat (6 * P) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
